// File: rtl/cms_axis_downsizer_pkg.sv
// Shared constants, item type and sizing helper for the CMS AXI-stream downsizer.
package cms_axis_downsizer_pkg;

  localparam int AXI_DATA_WIDTH          = 1024;
  localparam int CMS_DOWNSIZER_OUT_WIDTH = 64;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic                      last;
  } cms_item_t;

  function automatic int beats_per_item(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/cms_axis_downsizer_if.sv
// AXI-stream handshake bundle used for both the wide input and narrow output sides.
interface cms_axis_downsizer_if #(
  parameter int WIDTH = 64
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/cms_axis_downsizer_item_buffer.sv
// DEPTH-entry FIFO of {last, data} items; the caller gates push on !full and pop on !empty.
module cms_axis_downsizer_item_buffer
  import cms_axis_downsizer_pkg::*;
#(
  parameter int WIDTH = AXI_DATA_WIDTH + 1,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/cms_axis_downsizer.sv
// Splits wide trace items into LSB-first narrow beats; define
// CMS_AXIS_DOWNSIZER_ITEM_COUNTER_EN to add the items_forwarded output.
module cms_axis_downsizer
  import cms_axis_downsizer_pkg::*;
#(
  parameter int IN_WIDTH  = AXI_DATA_WIDTH,
  parameter int OUT_WIDTH = CMS_DOWNSIZER_OUT_WIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cms_axis_downsizer_if.slave   S_AXIS,
  cms_axis_downsizer_if.master  M_AXIS,
  output logic                  busy
`ifdef CMS_AXIS_DOWNSIZER_ITEM_COUNTER_EN
  ,
  output logic [31:0]           items_forwarded
`endif
);

  localparam int BEATS = beats_per_item(IN_WIDTH, OUT_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_width
    $error("cms_axis_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cms_axis_downsizer: DEPTH must be a power of 2 and at least 2");
  end

  logic [IN_WIDTH:0]        head;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     beat_hs;
  logic                     last_beat;
  logic [BW-1:0]            beat_idx;

  cms_axis_downsizer_item_buffer #(
    .WIDTH (IN_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({S_AXIS.tlast, S_AXIS.tdata}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // tready comes only from registered occupancy, so a pop never frees a slot in the same cycle.
  assign S_AXIS.tready = !full;
  assign push          = S_AXIS.tvalid && !full;

  assign M_AXIS.tvalid = !empty;
  assign beat_hs       = !empty && M_AXIS.tready;
  assign last_beat     = (beat_idx == LAST_BEAT);
  assign pop           = beat_hs && last_beat;
  assign M_AXIS.tdata  = head[int'(beat_idx)*OUT_WIDTH +: OUT_WIDTH];
  assign M_AXIS.tlast  = !empty && head[IN_WIDTH] && last_beat;
  assign busy          = (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx <= '0;
    end else if (beat_hs) begin
      beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
    end
  end

`ifdef CMS_AXIS_DOWNSIZER_ITEM_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      items_forwarded <= '0;
    end else if (pop) begin
      items_forwarded <= items_forwarded + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cms_axis_downsizer.md
Name: cms_axis_downsizer

Overview:
- Sits directly downstream of the continuous monitoring system's M_AXIS master port. Consumes wide trace items (default 1024 bits) and re-emits each one as narrow beats (default 64 bits) for a DMA or FIFO slave.
- A 2-entry item buffer decouples the two sides. Upstream can deposit the next item while the current one drains.
- tlast marks an item boundary only. It is carried forward onto the final narrow beat of that item.

Parameters:
- IN_WIDTH, 1024: width of the input item (matches AXI_DATA_WIDTH).
- OUT_WIDTH, 64: width of an output beat. IN_WIDTH must be a multiple of OUT_WIDTH; elaboration-time assertion fails otherwise.
- DEPTH, 2: number of item buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- S_AXIS_tvalid  input  1  upstream item valid.
- S_AXIS_tready  output  1  buffer can accept an item.
- S_AXIS_tdata  input  IN_WIDTH  wide item.
- S_AXIS_tlast  input  1  item closes a transfer.
- M_AXIS_tvalid  output  1  narrow beat valid.
- M_AXIS_tready  input  1  downstream accepts beat.
- M_AXIS_tdata  output  OUT_WIDTH  narrow beat.
- M_AXIS_tlast  output  1  last beat of an item that had tlast set.
- busy  output  1  buffer non-empty.

Behaviour:
- Constant: BEATS = IN_WIDTH/OUT_WIDTH (16 by default).
- State: DEPTH entries of {data, last}; wr_ptr and rd_ptr of log2(DEPTH) bits each; count of log2(DEPTH)+1 bits; beat_idx of log2(BEATS) bits.
- Reset (async assert, synchronous deassert handled externally): pointers, count, beat_idx and every entry go to 0. Outputs during and after reset: S_AXIS_tready=1, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, busy=0.
- A reset arriving mid-item discards all buffered data. No partial item is emitted afterwards.
- S_AXIS_tready = (count != DEPTH). It is a function of registered count only, with no combinational path from M_AXIS_tready.
- Push: on S_AXIS_tvalid && S_AXIS_tready, the entry at wr_ptr gets {tdata, tlast}; wr_ptr increments and wraps modulo DEPTH.
- M_AXIS_tvalid = (count != 0).
- M_AXIS_tdata = entry[rd_ptr].data[beat_idx*OUT_WIDTH +: OUT_WIDTH]. Beat order is LSB slice first.
- M_AXIS_tlast = M_AXIS_tvalid && entry[rd_ptr].last && (beat_idx == BEATS-1).
- Beat handshake: on M_AXIS_tvalid && M_AXIS_tready, beat_idx increments.
  - If beat_idx == BEATS-1: beat_idx returns to 0, rd_ptr increments (wraps), and the entry is popped.
- Latency: an item accepted at edge N presents its first beat from the cycle after edge N. There is no bypass; an empty buffer always costs 1 cycle.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, tready=0 even if a pop happens that cycle. The freed slot is visible the next cycle.
- Backpressure: while M_AXIS_tready=0, tdata and tlast stay stable and beat_idx holds (AXI-stream rule).
- Upstream must hold tdata/tlast stable while tready=0. The block does not check this.
- Throughput: one beat per cycle with tready held high. Sustained input rate is therefore 1 item per BEATS cycles.
- busy = (count != 0).

Optional Feature:
- Macro: CMS_AXIS_DOWNSIZER_ITEM_COUNTER_EN.
- When defined: adds output items_forwarded [31:0].
  - Increments on every pop (last beat handshake). Wraps 0xFFFFFFFF -> 0.
  - Resets to 0.
  - A pop coinciding with reset deassertion is not counted.
- When not defined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- continuous_monitoring_system_pkg gains:
  - CMS_DOWNSIZER_OUT_WIDTH = 64;
  - function beats_per_item(in_w, out_w);
  - typedef struct packed {logic [AXI_DATA_WIDTH-1:0] data; logic last;} cms_item_t.
- Sub-module cms_item_buffer: a parameterised DEPTH-entry FIFO of cms_item_t with push/pop/full/empty/count/head.
- The downsizer top holds beat_idx, slice mux and AXI glue only.

Test Plan:
- Single item, no backpressure: push item i-th 64-bit slice = i (0..15) with tlast=1, M_AXIS_tready=1.
  - Expect: tdata 0,1,...,15 on 16 consecutive cycles starting 1 cycle after acceptance; tlast only on the beat with value 15; busy=0 afterwards.
- Fill to full: push 3 items back-to-back with M_AXIS_tready=0.
  - Expect: tready=0 after the 2nd accept, 3rd held.
  - Raise tready: 3rd item is accepted in the cycle after the first item's 16th beat handshake; 48 beats total, in order.
- Backpressure stability: toggle M_AXIS_tready 1,0,0,1 repeatedly during one item (tlast=0).
  - Expect: tdata constant across stall cycles, exactly 16 beats emitted, M_AXIS_tlast never 1.
- Simultaneous push/pop: with count=1, push a new item on the same edge the last beat of the current item is popped.
  - Expect: count stays 1; the next beat is slice 0 of the new item; no gap cycle.
- Reset mid-item: assert rst asynchronously after 5 beats.
  - Expect: M_AXIS_tvalid=0 immediately, S_AXIS_tready=1; after release, a new item starts at slice 0.
- With CMS_AXIS_DOWNSIZER_ITEM_COUNTER_EN: forward 5 items. Expect items_forwarded=5.
